// File: rtl/demux_buf.sv
// -----------------------------------------------------------------------------
// demux_buf: registered 1-to-2 stream demultiplexer.
//
// One valid/ready input stream is steered per transfer by in_sel
// (1 -> port A, 0 -> port B) into one of two independent 2-entry FIFOs, so a
// stalled consumer only blocks traffic headed to its own port.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   in_valid/in_ready     input handshake
//   in_data [N], in_sel   payload and destination select
//   a_valid/a_ready/a_data  output A (head of FIFO A)
//   b_valid/b_ready/b_data  output B (head of FIFO B)
//   a_count, b_count      16-bit completed-transfer counters
//
// Build option: define DEMUX_BUF_COUNT_EN to build the wrapping per-port
// transfer counters; otherwise a_count/b_count are constant 0.
// -----------------------------------------------------------------------------
module demux_buf #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_sel,
    output logic         a_valid,
    input  logic         a_ready,
    output logic [N-1:0] a_data,
    output logic         b_valid,
    input  logic         b_ready,
    output logic [N-1:0] b_data,
    output logic [15:0]  a_count,
    output logic [15:0]  b_count
);

    // Complete state of one 2-entry FIFO.
    typedef struct packed {
        logic [1:0][N-1:0] mem;
        logic              wptr;
        logic              rptr;
        logic [1:0]        cnt;   // occupancy 0..2
    } fifo_t;

    fifo_t fifo_a_q, fifo_a_d;
    fifo_t fifo_b_q, fifo_b_d;

    logic a_full, b_full;
    logic push_a, push_b, pop_a, pop_b;

    // Next state of one FIFO. A simultaneous push and pop moves both
    // pointers and leaves the count unchanged.
    function automatic fifo_t fifo_next(input fifo_t f, input logic push,
                                        input logic pop, input logic [N-1:0] data);
        fifo_t n;
        n = f;
        if (push) begin
            n.mem[f.wptr] = data;
            n.wptr        = ~f.wptr;
        end
        if (pop) begin
            n.rptr = ~f.rptr;
        end
        if (push && !pop) begin
            n.cnt = f.cnt + 2'd1;
        end else if (pop && !push) begin
            n.cnt = f.cnt - 2'd1;
        end
        return n;
    endfunction

    assign a_full  = (fifo_a_q.cnt == 2'd2);
    assign b_full  = (fifo_b_q.cnt == 2'd2);
    assign a_valid = (fifo_a_q.cnt != 2'd0);
    assign b_valid = (fifo_b_q.cnt != 2'd0);
    assign a_data  = fifo_a_q.mem[fifo_a_q.rptr];
    assign b_data  = fifo_b_q.mem[fifo_b_q.rptr];

    // Ready depends only on the selected FIFO's fullness, never on the
    // downstream ready, so a pop into a full FIFO frees the slot next cycle.
    assign in_ready = in_sel ? !a_full : !b_full;

    // NOTE: every always_comb output is given a default first so that no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        push_a   = in_valid && in_ready && in_sel;
        push_b   = in_valid && in_ready && !in_sel;
        pop_a    = a_valid && a_ready;
        pop_b    = b_valid && b_ready;
        fifo_a_d = fifo_next(fifo_a_q, push_a, pop_a, in_data);
        fifo_b_d = fifo_next(fifo_b_q, push_b, pop_b, in_data);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the storage words are reset too, because the stale head
            // word is visible on a_data/b_data and must read 0 after reset.
            fifo_a_q <= '0;
            fifo_b_q <= '0;
        end else begin
            fifo_a_q <= fifo_a_d;
            fifo_b_q <= fifo_b_d;
        end
    end

`ifdef DEMUX_BUF_COUNT_EN
    logic [15:0] a_count_q, a_count_d;
    logic [15:0] b_count_q, b_count_d;

    // Counters wrap naturally from 65535 to 0.
    always_comb begin
        a_count_d = a_count_q;
        b_count_d = b_count_q;
        if (pop_a) a_count_d = a_count_q + 16'd1;
        if (pop_b) b_count_d = b_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_count_q <= '0;
            b_count_q <= '0;
        end else begin
            a_count_q <= a_count_d;
            b_count_q <= b_count_d;
        end
    end

    assign a_count = a_count_q;
    assign b_count = b_count_q;
`else
    assign a_count = '0;
    assign b_count = '0;
`endif

endmodule

// File: tb/tb_demux_buf.sv
// -----------------------------------------------------------------------------
// tb_demux_buf: directed self-checking bench for demux_buf (N = 32).
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too, after combinational settling and well away from the next edge.
// -----------------------------------------------------------------------------
module tb_demux_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sel;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [31:0] b_data;
    logic [15:0] a_count;
    logic [15:0] b_count;

    int total = 0;
    int bad   = 0;

    demux_buf #(.N(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_data  = '0;
        in_sel   = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL reset_a_valid: got %b want 0", a_valid); end
        total++; if (b_valid !== 1'b0) begin bad++; $display("FAIL reset_b_valid: got %b want 0", b_valid); end
        total++; if (a_data !== 32'h0) begin bad++; $display("FAIL reset_a_data: got %h want 0", a_data); end
        total++; if (b_data !== 32'h0) begin bad++; $display("FAIL reset_b_data: got %h want 0", b_data); end
        in_sel = 1'b1; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_sel1: got %b want 1", in_ready); end
        in_sel = 1'b0; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_sel0: got %b want 1", in_ready); end
        total++; if (a_count !== 16'd0) begin bad++; $display("FAIL reset_a_count: got %0d want 0", a_count); end
        total++; if (b_count !== 16'd0) begin bad++; $display("FAIL reset_b_count: got %0d want 0", b_count); end
    endtask

    task automatic test_basic_routing();
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 32'h1111_1111;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL route_ready_a: got %b want 1", in_ready); end
        step();
        in_sel  = 1'b0;
        in_data = 32'h2222_2222;
        #1;
        total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL route_a_valid: got %b want 1", a_valid); end
        total++; if (a_data !== 32'h1111_1111) begin bad++; $display("FAIL route_a_data: got %h want 11111111", a_data); end
        total++; if (b_valid !== 1'b0) begin bad++; $display("FAIL route_b_idle: got %b want 0", b_valid); end
        step();
        in_valid = 1'b0;
        #1;
        total++; if (b_valid !== 1'b1) begin bad++; $display("FAIL route_b_valid: got %b want 1", b_valid); end
        total++; if (b_data !== 32'h2222_2222) begin bad++; $display("FAIL route_b_data: got %h want 22222222", b_data); end
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL route_a_one_cycle: got %b want 0", a_valid); end
        step();
        total++; if (b_valid !== 1'b0) begin bad++; $display("FAIL route_b_one_cycle: got %b want 0", b_valid); end
        idle_inputs();
    endtask

    task automatic test_fill_stall();
        idle_inputs();
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 32'hA0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_accept_a0: got %b want 1", in_ready); end
        step();
        in_data = 32'hA1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_accept_a1: got %b want 1", in_ready); end
        total++; if (a_data !== 32'hA0) begin bad++; $display("FAIL fill_head_a0: got %h want a0", a_data); end
        step();
        in_data = 32'hA2;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_full_a: got %b want 0", in_ready); end
        step();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_still_full: got %b want 0", in_ready); end
        // B stays open while A is stalled.
        in_sel  = 1'b0;
        in_data = 32'hB0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_b_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        #1;
        total++; if (b_valid !== 1'b1) begin bad++; $display("FAIL stall_b_valid: got %b want 1", b_valid); end
        total++; if (b_data !== 32'hB0) begin bad++; $display("FAIL stall_b_data: got %h want b0", b_data); end
        b_ready = 1'b1;
        step();
        // Drain A while offering A2.
        a_ready  = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 32'hA2;
        #1;
        total++; if (b_valid !== 1'b0) begin bad++; $display("FAIL stall_b_drained: got %b want 0", b_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL drain_ready_before_pop: got %b want 0", in_ready); end
        total++; if (a_data !== 32'hA0) begin bad++; $display("FAIL drain_a0: got %h want a0", a_data); end
        step();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL drain_ready_after_pop: got %b want 1", in_ready); end
        total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL drain_a1_valid: got %b want 1", a_valid); end
        total++; if (a_data !== 32'hA1) begin bad++; $display("FAIL drain_a1: got %h want a1", a_data); end
        step();
        in_valid = 1'b0;
        #1;
        total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL drain_a2_valid: got %b want 1", a_valid); end
        total++; if (a_data !== 32'hA2) begin bad++; $display("FAIL drain_a2: got %h want a2", a_data); end
        step();
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL drain_a_empty: got %b want 0", a_valid); end
        idle_inputs();
    endtask

    task automatic test_simul_push_pop();
        idle_inputs();
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 32'hB5;
        step();
        // One entry held; push and pop together.
        in_data = 32'hC0;
        a_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL pp_ready: got %b want 1", in_ready); end
        total++; if (a_data !== 32'hB5) begin bad++; $display("FAIL pp_head_before: got %h want b5", a_data); end
        step();
        a_ready = 1'b0;
        in_data = 32'hC1;
        #1;
        total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL pp_valid_after: got %b want 1", a_valid); end
        total++; if (a_data !== 32'hC0) begin bad++; $display("FAIL pp_head_after: got %h want c0", a_data); end
        // Count must be 1: one more push is accepted, then the FIFO is full.
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL pp_count_one: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        #1;
        in_sel = 1'b1; #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL pp_full_after: got %b want 0", in_ready); end
        a_ready = 1'b1;
        step();
        total++; if (a_data !== 32'hC1) begin bad++; $display("FAIL pp_second: got %h want c1", a_data); end
        step();
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL pp_empty: got %b want 0", a_valid); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 32'hD0;
        step();
        in_data = 32'hD1;
        step();
        in_sel  = 1'b0;
        in_data = 32'hD2;
        step();
        // A holds 2, B holds 1; reset with every handshake input high.
        reset    = 1'b1;
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 32'hD3;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        #1;
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL rmid_a_valid: got %b want 0", a_valid); end
        total++; if (b_valid !== 1'b0) begin bad++; $display("FAIL rmid_b_valid: got %b want 0", b_valid); end
        total++; if (a_data !== 32'h0) begin bad++; $display("FAIL rmid_a_data: got %h want 0", a_data); end
        total++; if (b_data !== 32'h0) begin bad++; $display("FAIL rmid_b_data: got %h want 0", b_data); end
        total++; if (a_count !== 16'd0) begin bad++; $display("FAIL rmid_a_count: got %0d want 0", a_count); end
        total++; if (b_count !== 16'd0) begin bad++; $display("FAIL rmid_b_count: got %0d want 0", b_count); end
        step();
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL rmid_a_stays_empty: got %b want 0", a_valid); end
        idle_inputs();
    endtask

    task automatic test_count_wrap();
        int n_xfer;
`ifdef DEMUX_BUF_COUNT_EN
        n_xfer = 65537;
`else
        n_xfer = 40;
`endif
        idle_inputs();
        reset = 1'b1;
        step();
        reset    = 1'b0;
        a_ready  = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b1;
        for (int i = 0; i < n_xfer; i++) begin
            in_data = i;
            step();
`ifndef DEMUX_BUF_COUNT_EN
            total++; if (a_count !== 16'd0 || b_count !== 16'd0) begin bad++; $display("FAIL nocount_zero: got a=%0d b=%0d want 0 0", a_count, b_count); end
`endif
        end
        in_valid = 1'b0;
        step();
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL wrap_drained: got %b want 0", a_valid); end
`ifdef DEMUX_BUF_COUNT_EN
        total++; if (a_count !== 16'd1) begin bad++; $display("FAIL wrap_a_count: got %0d want 1", a_count); end
`else
        total++; if (a_count !== 16'd0) begin bad++; $display("FAIL wrap_a_count: got %0d want 0", a_count); end
`endif
        total++; if (b_count !== 16'd0) begin bad++; $display("FAIL wrap_b_count: got %0d want 0", b_count); end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_routing();
        test_fill_stall();
        test_simul_push_pop();
        test_reset_mid();
        test_count_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_buf.md
# demux_buf

Registered 1-to-2 stream demultiplexer that routes one valid/ready input stream to one of two output streams, selected per transfer by `in_sel`. Each output has its own 2-entry FIFO, so a stalled output never blocks traffic to the other output once its own FIFO has room. It is the splitting counterpart of the 2:1 `mux` in the datapath, and uses the same select convention: `in_sel=1` routes to port A and `in_sel=0` routes to port B. It sits between a producer stage and two consumer stages, for example a writeback result steered to one of two destination buffers.

## Interface
- `N`, default 32: data width in bits.
- `DEPTH`, fixed at 2: entries per output FIFO. This is not a parameter.

Ports (clock and reset first):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input transfer offered.
- `in_ready`  out  1  input can be accepted.
- `in_data`  in  N  input payload.
- `in_sel`  in  1  destination: 1 selects A, 0 selects B.
- `a_valid`  out  1  FIFO A non-empty.
- `a_ready`  in  1  consumer A accepts.
- `a_data`  out  N  head of FIFO A.
- `b_valid`  out  1  FIFO B non-empty.
- `b_ready`  in  1  consumer B accepts.
- `b_data`  out  N  head of FIFO B.
- `a_count`  out  16  transfers completed on A (see Configuration).
- `b_count`  out  16  transfers completed on B (see Configuration).

## Operation
- Handshake: a transfer occurs on any rising edge where `valid && ready`. The producer holds `in_data` and `in_sel` stable while `in_valid=1` and `in_ready=0`.
- `in_ready = in_sel ? !a_full : !b_full`. This is combinational from `in_sel` and FIFO state only. It never depends on `a_ready` or `b_ready`, and `in_valid` does not gate it.
- Each FIFO is 2 entries deep, with a 1-bit write pointer, a 1-bit read pointer and a 2-bit occupancy count (0..2).
  - full = (count==2); empty = (count==0).
- Push: an input handshake writes `in_data` into the FIFO selected by `in_sel`. The other FIFO is untouched.
- Pop: an output handshake (`a_valid && a_ready`) advances the read pointer of FIFO A. Port B behaves the same way.
- Simultaneous push and pop on the same FIFO:
  - The count is unchanged and both pointers advance.
  - A push is only possible when the FIFO is not full, so this cannot happen on a full FIFO. A pop arriving at a full FIFO frees a slot that is usable from the next cycle.
- A push to A and a pop from B in the same cycle are independent and both take effect.
- Order is preserved within each output. No ordering is defined between A and B.
- `a_valid = !a_empty`, and `a_data` = entry at the read pointer. Port B is the same.
- While `a_valid=0`, `a_data` shows the stale storage word. Consumers must ignore it.
- Reset:
  - Pointers, counts and storage are cleared to 0, so `a_valid=b_valid=0`, `a_data=b_data=0` and `a_count=b_count=0`.
  - `in_ready` becomes 1 once reset releases, since both FIFOs are empty.
  - Reset mid-operation discards all buffered entries with no output handshake.
  - While `reset=1`, no push or pop takes effect, even if the handshake signals are high.

## Timing
- Latency: a word accepted at edge t appears on `a_valid`/`a_data` (or `b_*`) in the cycle following edge t. This is 1 cycle of latency, with no combinational path from input to output.
- Throughput: 1 transfer per cycle per output, sustained while that consumer holds its ready high.
- Backpressure: after 2 accepted words with the consumer stalled, `in_ready` for that `in_sel` drops in the next cycle. It reasserts in the cycle after the first pop.
- `in_ready` may change in the same cycle that `in_sel` changes (combinational select).

## Configuration
- Macro: `DEMUX_BUF_COUNT_EN`.
- Defined:
  - `a_count` increments by 1 on every A output handshake; `b_count` does the same on every B output handshake.
  - Both are 16-bit and wrap from 65535 to 0.
  - Both are reset to 0.
- Not defined:
  - The counter registers are not built.
  - `a_count` and `b_count` are tied to constant 0.
  - Ports are present in both builds.

## Test plan
- Reset then idle:
  - After `reset` is held for 2 cycles, check `a_valid=b_valid=0`, `a_data=b_data=0`, `in_ready=1` for both `in_sel` values, and counts 0.
- Basic routing:
  - Stimulus: push 0x11111111 with `in_sel=1`, then 0x22222222 with `in_sel=0`, with `a_ready=b_ready=1`.
  - Required: A shows 0x11111111 one cycle after its accept, and B shows 0x22222222 one cycle after its accept. Each valid lasts one cycle.
- Fill and stall:
  - Stimulus: `a_ready=0`; push 0xA0, 0xA1, 0xA2 to A.
  - Required: 0xA0 and 0xA1 are accepted and `in_ready` goes to 0 for `in_sel=1`.
  - With `in_sel=0` during the stall: `in_ready=1`, and a push of 0xB0 appears on B.
  - Then raise `a_ready`: A emits 0xA0, 0xA1, then 0xA2 in order.
- Simultaneous push and pop:
  - Stimulus: A holds 1 entry; push 0xC0 to A while `a_ready=1` in the same cycle.
  - Required: count stays 1 and the next head is 0xC0.
- Reset mid-operation:
  - Stimulus: A holds 2 entries and B holds 1; assert `reset` for 1 cycle with `a_ready=b_ready=1` and `in_valid=1`.
  - Required: no handshake counted, all valids 0 afterward, and the counts reset to 0.
- Counter wrap (`DEMUX_BUF_COUNT_EN` defined):
  - Stimulus: 65537 A transfers.
  - Required: `a_count=1` and `b_count=0`.
  - Without the macro, both counts stay 0 throughout.
